memory_bank: RTL
================

MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of stored words (≥2).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, meaning address width, ≥ clog2(DEPTH).
REQ-004 The block SHALL have port clock  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port addr  input  ADDR_WIDTH  word address for read/write.
REQ-007 The block SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 The block SHALL have port select  input  1  bank select; no access without it.
REQ-009 The block SHALL have port rE  input  1  read request.
REQ-010 The block SHALL have port wE  input  1  write request.
REQ-011 The block SHALL have port clear  input  1  start a clear sweep of all words.
REQ-012 The block SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-013 The block SHALL have port rvalid  output  1  data_out updated by a read this cycle.
REQ-014 The block SHALL have port busy  output  1  clear sweep in progress.
REQ-015 The block SHALL have port err  output  1  out-of-range access flagged.

Function
REQ-016 Accepted access: select=1, busy=0, clear=0, addr<DEPTH; all state updates occur on the rising edge of clock.
REQ-017 Accepted write (wE=1): mem[addr] <= data_in at that edge.
REQ-018 Accepted read (rE=1): data_out <= mem[addr] and rvalid <= 1 at that edge, so data is visible one cycle after the request (latency 1).
REQ-019 rvalid SHALL be 1 for exactly one cycle per accepted read and 0 otherwise; back-to-back reads yield rvalid high on consecutive cycles.
REQ-020 data_out SHALL hold its last value when no read is accepted; it is never high-impedance.
REQ-021 Simultaneous read and write to the same address SHALL be read-first: data_out receives the pre-write contents; the new data is readable from the next request.
REQ-022 select=1 with (rE|wE)=1 and addr≥DEPTH: no memory change, rvalid 0, err <= 1 for one cycle; err is 0 in all other cycles.
REQ-023 State machine states: IDLE, CLEAR. IDLE→CLEAR on a clock edge with clear=1 (select not required); ptr <= 0, busy <= 1.
REQ-024 In CLEAR, each cycle: mem[ptr] <= 0 and ptr <= ptr+1; when ptr==DEPTH-1, the block SHALL write that word and return to IDLE, with busy <= 0 on the same edge.
REQ-025 A sweep SHALL take exactly DEPTH cycles with busy=1; the first access is accepted on the cycle after busy falls.
REQ-026 While busy=1: reads and writes are ignored (no rvalid, no err, no memory change), and clear is ignored.
REQ-027 clear=1 together with an access request in IDLE: clear wins and the access is dropped (no rvalid, no err).
REQ-028 ptr SHALL be ADDR_WIDTH bits and never index ≥ DEPTH, including when DEPTH is not a power of two.

Reset
REQ-029 reset=0 SHALL asynchronously set every mem word to 0, data_out=0, rvalid=0, err=0, busy=0, state=IDLE and ptr=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep to IDLE with all words 0; there is no resumption after release.
REQ-031 After reset release, the first rising edge SHALL accept an access normally.

Verification
REQ-032 Write 8'hA5 @addr 3, then read addr 3 -> next cycle data_out=8'hA5, rvalid=1 for one cycle, err=0.
REQ-033 Same cycle rE=wE=1 @addr 5 (old 8'h11, new 8'h22) -> data_out=8'h11; a subsequent read of addr 5 -> 8'h22.
REQ-034 Fill all 16 words with nonzero values, pulse clear -> busy=1 for exactly 16 cycles, a write during busy is dropped, then a read of every word returns 0.
REQ-035 Read/write @addr 17 with DEPTH=16, ADDR_WIDTH=5 -> err=1 for one cycle, rvalid=0, memory unchanged.
REQ-036 Reset pulse at sweep cycle 7 -> busy=0 immediately, data_out=0, all words read 0; clear with wE in the same cycle -> write dropped.

Source files
------------

// File: rtl/memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : memory_bank
// Purpose  : Single-bank word memory with registered read port, range
//            checking and a self-timed clear sweep that zeroes every word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   1           rising-edge clock
//   reset    in   1           asynchronous, active-low reset
//   addr     in   ADDR_WIDTH  word address for read/write
//   data_in  in   DATA_WIDTH  write data
//   select   in   1           bank select; no access without it
//   rE       in   1           read request
//   wE       in   1           write request
//   clear    in   1           start a clear sweep of all words
//   data_out out  DATA_WIDTH  registered read data (latency 1)
//   rvalid   out  1           data_out updated by a read this cycle
//   busy     out  1           clear sweep in progress
//   err      out  1           out-of-range access flagged
// ============================================================================
module memory_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  select,
  input  logic                  rE,
  input  logic                  wE,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  err
);

  // One extra bit so DEPTH itself is representable even when it equals
  // 2**ADDR_WIDTH; the range test then never wraps.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_next;
  logic                    sweep_wr;

  logic                    in_range;
  logic                    access_req;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    err_next;
  logic [DATA_WIDTH-1:0]   read_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // --------------------------------------------------------------------------
  // Access qualification. Clear in IDLE pre-empts any access in the same
  // cycle, and nothing is accepted while a sweep is running.
  // --------------------------------------------------------------------------
  always_comb begin
    in_range   = ({1'b0, addr} < DEPTH_EXT);
    access_req = select & (rE | wE) & (state == IDLE) & ~clear;
    rd_accept  = access_req & in_range & rE;
    wr_accept  = access_req & in_range & wE;
    err_next   = access_req & ~in_range;
  end

  // --------------------------------------------------------------------------
  // Clear-sweep state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sweep_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        sweep_wr = 1'b1;
        // Stop on the last real word so ptr never reaches DEPTH, which
        // matters when DEPTH is not a power of two.
        if (ptr == LAST_PTR) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // --------------------------------------------------------------------------
  // Storage. Per-word enables decoded against constants keep every index
  // inside 0..DEPTH-1 regardless of the address width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_wr && (ptr == ADDR_WIDTH'(i))) begin
          mem[i] <= '0;
        end else if (wr_accept && (addr == ADDR_WIDTH'(i))) begin
          mem[i] <= data_in;
        end
      end
    end
  end

  always_comb begin
    read_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        read_word = mem[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port and flags. read_word is taken from the array before
  // the same edge's write lands, giving read-first behaviour.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= rd_accept;
      err    <= err_next;
      if (rd_accept) begin
        data_out <= read_word;
      end
    end
  end

endmodule
`default_nettype wire
